// File: rtl/maxpool_32_2_16.sv
// Streaming 1-D max-pool: reduces each K-sample window to its signed max,
// flags the last pooled sample of every L-sample frame, 2-entry output FIFO.
module maxpool_32_2_16 #(
  parameter int L = 32,
  parameter int K = 2,
  parameter int T = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                y_last
);

  localparam int N  = L / K;
  localparam int WW = (K > 1) ? $clog2(K) : 1;
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WW-1:0] WLAST = WW'(K - 1);
  localparam logic [OW-1:0] OLAST = OW'(N - 1);

  logic [WW-1:0]       win_cnt_q, win_cnt_d;
  logic [OW-1:0]       out_cnt_q, out_cnt_d;
  logic signed [T-1:0] run_max_q, run_max_d;
  logic [T:0]          mem0_q, mem0_d;
  logic [T:0]          mem1_q, mem1_d;
  logic [1:0]          count_q, count_d;

  logic                in_beat;
  logic                out_beat;
  logic                push;
  logic                last;
  logic signed [T-1:0] cand;
  logic [T:0]          entry;

  assign x_ready = !reset && (count_q != 2'd2);
  assign y_valid = (count_q != 2'd0);
  assign y_data  = mem0_q[T-1:0];
  assign y_last  = mem0_q[T];

  // Window max, counters and the pushed entry
  always_comb begin
    in_beat   = x_valid && x_ready;
    out_beat  = y_valid && y_ready;
    win_cnt_d = win_cnt_q;
    out_cnt_d = out_cnt_q;
    run_max_d = run_max_q;
    if (win_cnt_q == '0) begin
      cand = x_data;
    end else if (x_data > run_max_q) begin
      cand = x_data;
    end else begin
      cand = run_max_q;
    end
    push  = in_beat && (win_cnt_q == WLAST);
    last  = (out_cnt_q == OLAST);
    entry = {last, cand};
    if (in_beat) begin
      run_max_d = cand;
      if (push) begin
        win_cnt_d = '0;
        out_cnt_d = last ? '0 : out_cnt_q + 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  // Two-entry FIFO; mem0 is always the head
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (push && out_beat) begin
      mem0_d = entry;
    end else if (out_beat) begin
      mem0_d  = mem1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        mem0_d = entry;
      end else begin
        mem1_d = entry;
      end
      count_d = count_q + 2'd1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= '0;
      out_cnt_q <= '0;
      run_max_q <= '0;
      mem0_q    <= '0;
      mem1_q    <= '0;
      count_q   <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      out_cnt_q <= out_cnt_d;
      run_max_q <= run_max_d;
      mem0_q    <= mem0_d;
      mem1_q    <= mem1_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_maxpool_32_2_16.sv
// Self-checking bench for maxpool_32_2_16 against a queue-based
// software max-pool reference with FIFO occupancy model.
module tb_maxpool_32_2_16;

  localparam int L = 32;
  localparam int K = 2;
  localparam int N = L / K;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_data = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready = 1'b0;
  logic        y_last;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] win[$];
  logic [16:0]        exp_q[$];
  logic [15:0]        got[$];
  logic [15:0]        lastpos[$];
  int                 mcnt = 0;
  int                 ocnt = 0;

  maxpool_32_2_16 dut (
    .clk    (clk),
    .reset  (reset),
    .x_data (x_data),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .y_data (y_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y_last (y_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, g, e);
    end
  endtask

  task automatic model_clear();
    win.delete();
    exp_q.delete();
    mcnt = 0;
  endtask

  task automatic step(input bit vld, input logic [15:0] d,
                      input bit rdy, output bit took);
    bit mvalid;
    bit mready;
    logic signed [15:0] m;
    x_valid = vld;
    x_data  = d;
    y_ready = rdy;
    #1;
    mvalid = (exp_q.size() != 0);
    mready = (exp_q.size() < 2);
    chk("y_valid", y_valid, mvalid);
    chk("x_ready", x_ready, mready);
    if (mvalid) begin
      chk("y_data", y_data, exp_q[0][15:0]);
      chk("y_last", y_last, exp_q[0][16]);
      if (rdy) begin
        got.push_back(y_data);
        ocnt++;
        if (exp_q[0][16]) lastpos.push_back(16'(ocnt));
        exp_q.delete(0);
      end
    end
    took = vld && mready;
    if (took) begin
      win.push_back(d);
      if (win.size() == K) begin
        m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
        exp_q.push_back({(mcnt == N - 1), m});
        mcnt = (mcnt + 1) % N;
        win.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input bit rdy);
    bit t;
    int n;
    t = 1'b0;
    n = 0;
    while (!t && n < 100) begin
      step(1'b1, d, rdy, t);
      n++;
    end
    if (!t) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit t;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1'b0, 16'h0, 1'b1, t);
      n++;
    end
    step(1'b0, 16'h0, 1'b1, t);
    if (exp_q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit t;
    int i;
    int cyc;
    logic [15:0] sx [8];
    logic [15:0] sy [4];
    sx = '{16'hFFFB, 16'hFFFD, 16'h0007, 16'h0007,
           16'h8000, 16'h7FFF, 16'h0064, 16'hFF9C};
    sy = '{16'hFFFD, 16'h0007, 16'h7FFF, 16'h0064};

    // reset state
    @(negedge clk);
    #1;
    chk("rst_x_ready", x_ready, 1'b0);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_y_data", y_data, 16'h0);
    chk("rst_y_last", y_last, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // ramp frame, consumer always ready
    got.delete();
    lastpos.delete();
    ocnt = 0;
    for (int k = 0; k < L; k++) send(16'(k), 1'b1);
    drain();
    chk("ramp_count", got.size(), N);
    for (int k = 0; k < N && k < got.size(); k++)
      chk("ramp_val", got[k], 16'(2 * k + 1));
    chk("ramp_lastn", lastpos.size(), 1);
    if (lastpos.size() > 0) chk("ramp_lastpos", lastpos[0], 16'd16);

    // signed and tie windows
    got.delete();
    for (int k = 0; k < 8; k++) send(sx[k], 1'b1);
    drain();
    chk("sgn_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk("sgn_val", got[k], sy[k]);
    for (int k = 8; k < L; k++) send(16'h0, 1'b1);
    drain();

    // backpressure over a full frame
    got.delete();
    i = 0;
    cyc = 0;
    while (i < L && cyc < 500) begin
      step(1'b1, 16'(i), (cyc >= 8) && (cyc % 4 == 0), t);
      if (t) i++;
      cyc++;
    end
    if (i < L) chk("bp_timeout", i, L);
    drain();
    chk("bp_count", got.size(), N);
    for (int k = 0; k < N && k < got.size(); k++)
      chk("bp_val", got[k], 16'(2 * k + 1));

    // back-to-back frames
    got.delete();
    lastpos.delete();
    ocnt = 0;
    for (int k = 0; k < L; k++) send(16'(k), 1'b1);
    for (int k = 0; k < L; k++) send(16'(-100 - k), 1'b1);
    drain();
    chk("b2b_count", got.size(), 2 * N);
    if (got.size() > 16) chk("b2b_f2_first", got[16], 16'hFF9C);
    chk("b2b_lastn", lastpos.size(), 2);
    if (lastpos.size() > 1) begin
      chk("b2b_last1", lastpos[0], 16'd16);
      chk("b2b_last2", lastpos[1], 16'd32);
    end

    // reset mid-frame with one FIFO entry held
    for (int k = 0; k < 10; k++) send(16'(k), 1'b1);
    send(16'd10, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_y_valid", y_valid, 1'b0);
    chk("mid_rst_x_ready", x_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    got.delete();
    lastpos.delete();
    ocnt = 0;
    for (int k = 0; k < L; k++) send(16'(k), 1'b1);
    drain();
    chk("post_rst_count", got.size(), N);
    for (int k = 0; k < N && k < got.size(); k++)
      chk("post_rst_val", got[k], 16'(2 * k + 1));
    chk("post_rst_lastn", lastpos.size(), 1);
    if (lastpos.size() > 0) chk("post_rst_lastpos", lastpos[0], 16'd16);

    // random bubbles over three frames
    got.delete();
    lastpos.delete();
    ocnt = 0;
    i = 0;
    cyc = 0;
    while (i < 3 * L && cyc < 3000) begin
      step(1'($urandom % 2), 16'($urandom), 1'($urandom % 2), t);
      if (t) i++;
      cyc++;
    end
    if (i < 3 * L) chk("rnd_timeout", i, 3 * L);
    drain();
    chk("rnd_count", got.size(), 3 * N);
    chk("rnd_lastn", lastpos.size(), 3);
    for (int k = 0; k < lastpos.size(); k++)
      chk("rnd_lastpos", lastpos[k], 16'(N * (k + 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpool_32_2_16.md
# maxpool_32_2_16

Streaming 1-D max-pool stage that sits directly downstream of the 16-bit convolution layer (96-sample input, 65-tap filter, 2-way parallel). It consumes that layer's rectified output stream of L=32 samples per frame and reduces each non-overlapping window of K=2 consecutive samples to its maximum. It emits L/K=16 samples per frame on a valid/ready stream, flagging the last sample of each frame. A 2-entry output FIFO decouples producer and consumer, so the upstream layer is never stalled while space remains.

## Interface
- L, 32: input samples per frame; must be a multiple of K.
- K, 2: pool window size and stride (K ≥ 2).
- T, 16: sample width, signed two's complement.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- x_data  in  T  input sample, signed.
- x_valid  in  1  x_data valid.
- x_ready  out  1  block accepts x_data this cycle.
- y_data  out  T  pooled sample, signed.
- y_valid  out  1  y_data/y_last valid.
- y_ready  in  1  consumer accepts y_data this cycle.
- y_last  out  1  high with the final (L/K-th) pooled sample of a frame.

## Operation
- Input beat = x_valid && x_ready; output beat = y_valid && y_ready.
- Window counter win_cnt (0..K-1) and output counter out_cnt (0..L/K-1), both reset to 0.
- On an input beat with win_cnt==0: run_max <= x_data. Otherwise: run_max <= max(run_max, x_data), signed compare. Ties keep the value; results are identical either way.
- On an input beat with win_cnt==K-1:
  - push {max(run_max, x_data), last}, where last = (out_cnt==L/K-1);
  - win_cnt wraps to 0;
  - out_cnt increments, wrapping to 0 after L/K-1.
- Otherwise an input beat increments win_cnt.
- No arithmetic widening or saturation: outputs are exact input values.
- FIFO: 2 entries, each T+1 bits (data, last), with count 0..2.
  - y_valid = (count != 0); y_data/y_last come from the head entry.
- x_ready = !reset && (count < 2).
  - x_ready is a registered-state function only, with no combinational path from y_ready.
  - A window-closing beat therefore always has a free FIFO slot.
- Simultaneous push and pop:
  - count==1: count stays 1; the head advances and the new entry is written.
  - count==2: push is impossible because x_ready is low; a pop makes count 1.
- Frame boundaries are implicit. After out_cnt wraps, the next input starts a new frame with no idle cycles needed.
- Reset mid-frame: the partial window, counters and FIFO contents are discarded, and the next accepted input is sample 0 of a fresh frame.

## Timing
- Reset values:
  - x_ready=0 while reset is asserted, 1 on the first cycle after release;
  - y_valid=0, y_last=0, y_data=0;
  - win_cnt=0, out_cnt=0, count=0, run_max=0.
- Latency: the window-closing input beat at edge t gives y_valid=1 with the result from the cycle after t (visible before edge t+1).
- Throughput: 1 input per cycle sustained while the consumer holds y_ready=1; 1 output per K cycles.
- Backpressure: with y_ready=0, the FIFO fills after 2 windows. x_ready falls the cycle after the second push and rises the cycle after the first pop.
- Holding rules:
  - y_data/y_last stay stable while y_valid=1 && y_ready=0.
  - x_data is ignored when x_ready=0.

## Test plan
- Ramp frame x=0,1,…,31 with y_ready held 1 → y = 1,3,5,…,31.
  - Each output valid 1 cycle after the odd-index input.
  - y_last=1 only on the 31; x_ready stays 1 throughout.
- Signed and tie windows: inputs (-5,-3), (7,7), (-32768,32767), (100,-100) → outputs -3, 7, 32767, 100.
- Backpressure: y_ready=0 while streaming a full frame.
  - x_ready drops after the 4th input; y shows 1 stable.
  - Raise y_ready for one cycle → x_ready returns next cycle. No samples are lost or duplicated over the frame.
- Back-to-back frames: 2 frames of 32 samples with no gap.
  - 32 outputs; y_last on outputs 16 and 32.
  - Second-frame values are unaffected by the first frame's final run_max.
- Reset mid-frame: assert reset asynchronously after 11 inputs with 1 entry in the FIFO.
  - y_valid and x_ready drop immediately.
  - After release, a fresh 32-sample ramp → exactly 16 outputs 1,3,…,31, y_last on the 16th.
- Bubbles: x_valid toggled pseudo-randomly against random y_ready over 3 frames → output sequence matches the software max-pool reference, with y_last every 16th output.
